ysyx_23060203_pcu: RTL and testbench

Program-counter unit at the head of the pipeline. It holds the fetch PC, issues it to the IFU over a valid/ready handshake, and advances it sequentially. It accepts resolved control-flow results from the IDU (the branch-compare `jump_en` plus jal/jalr) and turns a taken result into a redirect with an epoch flip and a one-cycle flush. It traps on a misaligned target.

---
 rtl/ysyx_23060203_pcu.sv | 169 ++++++++++++++++
 tb/tb_ysyx_23060203_pcu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_pcu.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_pcu -- program-counter unit
//
// Holds the fetch PC and issues it to the IFU over a valid/ready handshake.
// It advances the PC sequentially, and applies resolved control-flow results
// from the IDU as redirects. Each redirect flips the fetch epoch and pulses
// flush. A taken target whose bit 1 is set raises a trap. The core has no
// compressed instructions, so such a target is misaligned.
//
// Ports
//   clock, reset_n      : clock and asynchronous active-low reset
//   if_valid/if_ready   : fetch request handshake; if_pc is the address and
//                         if_epoch the tag the IFU attaches to fetched words
//   flush               : one-cycle pulse on every redirect or trap entry
//   br_valid/br_ready   : resolved control-flow result handshake
//   br_kind             : 00 none, 01 conditional branch, 10 jal, 11 jalr
//   br_pc/br_imm/br_rs1 : operands used to form the target
//   jump_en             : branch-compare outcome (kind 01 only)
//   trap_valid/trap_addr: pending misaligned-target trap and its address
//   trap_ack            : trap handler takes the trap
//   redirect_cnt        : saturating count of taken redirects
// ----------------------------------------------------------------------------
module ysyx_23060203_pcu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic        if_epoch,
  output logic        flush,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [1:0]  br_kind,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [31:0] br_rs1,
  input  logic        jump_en,
  output logic        trap_valid,
  output logic [31:0] trap_addr,
  input  logic        trap_ack,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_e;

  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        epoch_q, epoch_d;
  logic        flush_q, flush_d;
  logic        trap_valid_q, trap_valid_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] cnt_q, cnt_d;

  logic        in_run;
  logic        acc;
  logic        taken;
  logic        misaligned;
  logic [31:0] tgt_base;
  logic [31:0] tgt_sum;
  logic [31:0] target;
  logic        cnt_sat;

  // Fetch requests and result acceptance are both tied to RUN. BOOT is a
  // settle cycle. TRAP freezes the front end until the handler acknowledges.
  assign in_run   = (state_q == S_RUN);
  assign if_valid = in_run;
  assign br_ready = in_run;

  assign acc   = br_valid & in_run;
  assign taken = acc & ((br_kind == KIND_JAL) | (br_kind == KIND_JALR) |
                        ((br_kind == KIND_BR) & jump_en));

  // A single adder serves all kinds. Only jalr uses rs1 as the base, and only
  // jalr clears bit 0 of the sum.
  assign tgt_base = (br_kind == KIND_JALR) ? br_rs1 : br_pc;
  assign tgt_sum  = tgt_base + br_imm;
  assign target   = (br_kind == KIND_JALR) ? {tgt_sum[31:1], 1'b0} : tgt_sum;

  assign misaligned = taken & target[1];
  assign cnt_sat    = &cnt_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epoch_d      = epoch_q;
    flush_d      = 1'b0;
    trap_valid_d = trap_valid_q;
    trap_addr_d  = trap_addr_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (misaligned) begin
          // PC and epoch stay put. Flushing still clears whatever was
          // fetched past the faulting control-flow instruction.
          state_d      = S_TRAP;
          trap_valid_d = 1'b1;
          trap_addr_d  = target;
          flush_d      = 1'b1;
        end else if (taken) begin
          // A redirect overrides any handshake in the same cycle. The request
          // accepted this cycle carries the old epoch and is dropped
          // downstream.
          pc_d    = target;
          epoch_d = ~epoch_q;
          flush_d = 1'b1;
          if (!cnt_sat) begin
            cnt_d = cnt_q + 32'd1;
          end
        end else if (if_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end

      S_TRAP: begin
        if (trap_ack) begin
          state_d      = S_RUN;
          trap_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      flush_q      <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_addr_q  <= 32'd0;
      cnt_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      flush_q      <= flush_d;
      trap_valid_q <= trap_valid_d;
      trap_addr_q  <= trap_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign if_pc        = pc_q;
  assign if_epoch     = epoch_q;
  assign flush        = flush_q;
  assign trap_valid   = trap_valid_q;
  assign trap_addr    = trap_addr_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060203_pcu.sv
module tb_ysyx_23060203_pcu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;

  logic        clock;
  logic        reset_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic        if_epoch;
  logic        flush;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_kind;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] br_rs1;
  logic        jump_en;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        trap_ack;
  logic [31:0] redirect_cnt;

  int n_total = 0;
  int n_pass  = 0;
  logic cmp_en   = 1'b0;
  logic force_on = 1'b0;

  // reference model state
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_ep;
  logic        m_flush;
  logic        m_tv;
  logic [31:0] m_ta;
  logic [31:0] m_cnt;

  ysyx_23060203_pcu #(.RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_epoch    (if_epoch),
    .flush       (flush),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_kind     (br_kind),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .br_rs1      (br_rs1),
    .jump_en     (jump_en),
    .trap_valid  (trap_valid),
    .trap_addr   (trap_addr),
    .trap_ack    (trap_ack),
    .redirect_cnt(redirect_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] calc_target(input logic [1:0] k, input logic [31:0] pc,
                                              input logic [31:0] imm, input logic [31:0] rs1);
    if (k == 2'b11) return (rs1 + imm) & ~32'h1;
    return pc + imm;
  endfunction

  // Behavioural model: what the fetch front end must look like after each edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_BOOT; m_pc = RST_PC; m_ep = 1'b0; m_flush = 1'b0;
      m_tv = 1'b0; m_ta = 32'd0; m_cnt = 32'd0;
    end else begin
      logic        fl;
      logic        tk;
      logic [31:0] t;
      fl = 1'b0;
      if (force_on) m_cnt = 32'hFFFF_FFFF;
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        tk = br_valid && (br_kind == 2'b10 || br_kind == 2'b11 || (br_kind == 2'b01 && jump_en));
        t  = calc_target(br_kind, br_pc, br_imm, br_rs1);
        if (tk && t[1]) begin
          m_mode = M_TRAP; m_tv = 1'b1; m_ta = t; fl = 1'b1;
        end else if (tk) begin
          m_pc = t; m_ep = ~m_ep; fl = 1'b1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (if_ready) begin
          m_pc = m_pc + 4;
        end
      end else begin
        if (trap_ack) begin
          m_mode = M_RUN; m_tv = 1'b0;
        end
      end
      m_flush = fl;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_if_valid",   {31'd0, if_valid},   {31'd0, (m_mode == M_RUN)});
      chk("cmp_br_ready",   {31'd0, br_ready},   {31'd0, (m_mode == M_RUN)});
      chk("cmp_if_pc",      if_pc,               m_pc);
      chk("cmp_if_epoch",   {31'd0, if_epoch},   {31'd0, m_ep});
      chk("cmp_flush",      {31'd0, flush},      {31'd0, m_flush});
      chk("cmp_trap_valid", {31'd0, trap_valid}, {31'd0, m_tv});
      chk("cmp_trap_addr",  trap_addr,           m_ta);
      chk("cmp_cnt",        redirect_cnt,        m_cnt);
    end
  end

  task automatic send_br(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic je);
    br_valid = 1'b1; br_kind = k; br_pc = pc; br_imm = imm; br_rs1 = rs1; jump_en = je;
    @(negedge clock);
    br_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; if_ready = 1'b0; br_valid = 1'b0; br_kind = 2'b00;
    br_pc = 32'd0; br_imm = 32'd0; br_rs1 = 32'd0; jump_en = 1'b0; trap_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    repeat (2) @(negedge clock);
    if_ready = 1'b1; reset_n = 1'b1;

    // sequential fetch
    @(negedge clock);
    chk("seq0_valid", {31'd0, if_valid}, 32'd1);
    chk("seq0_pc", if_pc, 32'h3000_0000);
    @(negedge clock);
    chk("seq1_pc", if_pc, 32'h3000_0004);
    @(negedge clock);
    chk("seq2_pc", if_pc, 32'h3000_0008);
    chk("seq2_flush", {31'd0, flush}, 32'd0);

    // taken conditional branch, then the same one untaken
    send_br(2'b01, 32'h3000_0010, 32'hFFFF_FFF0, 32'd0, 1'b1);
    chk("br_pc", if_pc, 32'h3000_0000);
    chk("br_epoch", {31'd0, if_epoch}, 32'd1);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_cnt", redirect_cnt, 32'd1);
    @(negedge clock);
    chk("br_flush_end", {31'd0, flush}, 32'd0);
    chk("br_next_pc", if_pc, 32'h3000_0004);
    send_br(2'b01, 32'h3000_0010, 32'hFFFF_FFF0, 32'd0, 1'b0);
    chk("nt_pc", if_pc, 32'h3000_0008);
    chk("nt_cnt", redirect_cnt, 32'd1);

    // misaligned jalr traps, ack resumes at the same PC
    send_br(2'b11, 32'd0, 32'd0, 32'h8000_0003, 1'b0);
    chk("trap_valid", {31'd0, trap_valid}, 32'd1);
    chk("trap_addr", trap_addr, 32'h8000_0002);
    chk("trap_if_valid", {31'd0, if_valid}, 32'd0);
    chk("trap_br_ready", {31'd0, br_ready}, 32'd0);
    chk("trap_pc", if_pc, 32'h3000_0008);
    @(negedge clock);
    trap_ack = 1'b1;
    @(negedge clock);
    trap_ack = 1'b0;
    chk("ack_trap_valid", {31'd0, trap_valid}, 32'd0);
    chk("ack_if_valid", {31'd0, if_valid}, 32'd1);
    chk("ack_pc", if_pc, 32'h3000_0008);

    // aligned jalr with a simultaneous handshake
    send_br(2'b11, 32'd0, 32'd4, 32'h8000_0001, 1'b0);
    chk("jalr_pc", if_pc, 32'h8000_0004);
    chk("jalr_cnt", redirect_cnt, 32'd2);

    // redirect during a stall, then the stall holds the PC
    if_ready = 1'b0;
    send_br(2'b10, 32'h0000_1000, 32'h0000_0100, 32'd0, 1'b0);
    chk("stall_jal_pc", if_pc, 32'h0000_1100);
    @(negedge clock);
    chk("stall_hold_pc", if_pc, 32'h0000_1100);

    // asynchronous reset mid-stall
    #3 reset_n = 1'b0;
    #1;
    chk("arst_pc", if_pc, RST_PC);
    chk("arst_cnt", redirect_cnt, 32'd0);
    chk("arst_epoch", {31'd0, if_epoch}, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1; if_ready = 1'b1;
    @(negedge clock);

    // PC wrap
    send_br(2'b10, 32'hFFFF_FFF0, 32'h0000_000C, 32'd0, 1'b0);
    chk("wrap_pre", if_pc, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap_post", if_pc, 32'h0000_0000);

    // counter saturation
    #2;
    force dut.cnt_q = 32'hFFFF_FFFF;
    force_on = 1'b1;
    @(negedge clock);
    #2;
    release dut.cnt_q;
    force_on = 1'b0;
    @(negedge clock);
    send_br(2'b10, 32'h0000_0100, 32'd0, 32'd0, 1'b0);
    chk("sat_cnt", redirect_cnt, 32'hFFFF_FFFF);
    chk("sat_pc", if_pc, 32'h0000_0100);

    // reset while in TRAP
    send_br(2'b11, 32'd0, 32'd0, 32'h0000_0003, 1'b0);
    chk("trap2_valid", {31'd0, trap_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("trap_rst_tv", {31'd0, trap_valid}, 32'd0);
    chk("trap_rst_pc", if_pc, RST_PC);
    chk("trap_rst_flush", {31'd0, flush}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      br_valid = ($urandom_range(0, 2) == 0);
      br_kind  = 2'($urandom_range(0, 3));
      br_pc    = $urandom & ~32'h3;
      br_imm   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
      br_rs1   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h2);
      jump_en  = 1'($urandom_range(0, 1));
      if_ready = ($urandom_range(0, 3) != 0);
      trap_ack = ($urandom_range(0, 3) == 0);
      if ((i % 400) == 399) begin
        #3 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
    end
    @(negedge clock);
    br_valid = 1'b0;
    @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
